// File: rtl/stack_sequencer.sv
// stack_sequencer: fetch/execute FSM that drives a stack datapath from a 16-bit instruction stream
module stack_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int TRAP_ON_OVERFLOW = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  input  logic [15:0] a_in,
  input  logic        Overflow,
  output logic [2:0]  stackOP,
  output logic [3:0]  aluOP,
  output logic        mux_selector,
  output logic [15:0] immediate,
  output logic        halted,
  output logic [1:0]  fault
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d;
  logic [1:0] fault_q, fault_d;
  logic [3:0] op;
  logic exec, illegal, trap;
  assign op = ir_q[15:12];
  assign exec = state_q == EXEC;
  assign illegal = op >= 4'h6 && op <= 4'hE;
  assign trap = op == 4'h3 && Overflow && TRAP_ON_OVERFLOW != 0;
  assign imem_req = state_q == FETCH;
  assign imem_addr = pc_q;
  assign halted = state_q == HALT;
  assign fault = fault_q;
  assign stackOP = !exec ? 3'b000 : op == 4'h1 ? 3'b001 : (op == 4'h2 || op == 4'h5) ? 3'b010 :
                   op == 4'h3 ? 3'b011 : 3'b000;
  assign aluOP = exec && op == 4'h3 ? ir_q[3:0] : 4'h0;
  assign mux_selector = exec && op == 4'h1;
  assign immediate = exec ? {{4{ir_q[11]}}, ir_q[11:0]} : 16'h0000;
  // next state, PC, IR and sticky fault; a jump in EXEC overrides the PC+1 taken at fetch
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: state_d = run ? FETCH : IDLE;
      FETCH: if (imem_valid) begin
        ir_d = imem_data;
        pc_d = pc_q + 16'd1;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = run ? FETCH : IDLE;
        if (op == 4'h4 || (op == 4'h5 && a_in == 16'h0000)) pc_d = {4'h0, ir_q[11:0]};
        if (op == 4'hF) state_d = HALT;
        if (illegal || trap) begin
          state_d = HALT;
          if (fault_q == 2'b00) fault_d = illegal ? 2'b10 : 2'b01;
        end
      end
      default: state_d = HALT;
    endcase
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      ir_q <= 16'h0000;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      fault_q <= fault_d;
    end
  end
endmodule
